// File: rtl/region_memory_controller.sv
// rtl/region_memory_controller.sv - registered base/mask region decoder between the core LSU and region ports (optional MEMORY_CONTROLLER_TIMEOUT_EN)
module region_memory_controller #(
    parameter int REGION_COUNT   = 2,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter logic [REGION_COUNT*ADDRESS_WIDTH-1:0] REGION_BASES = {32'h1000_0000, 32'h0000_0000},
    parameter logic [REGION_COUNT*ADDRESS_WIDTH-1:0] REGION_MASKS = {32'hF000_0000, 32'hFF00_0000},
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ADDRESS_WIDTH-1:0]             coreAddress,
    input  logic [DATA_WIDTH/8-1:0]              coreByteSelect,
    input  logic                                 coreWriteEnable,
    input  logic                                 coreReadEnable,
    input  logic [DATA_WIDTH-1:0]                coreDataWrite,
    output logic [DATA_WIDTH-1:0]                coreDataRead,
    output logic                                 coreBusy,
    output logic                                 coreFault,
    output logic [REGION_COUNT*ADDRESS_WIDTH-1:0] regionAddress,
    output logic [REGION_COUNT*DATA_WIDTH/8-1:0] regionByteSelect,
    output logic [REGION_COUNT-1:0]              regionWriteEnable,
    output logic [REGION_COUNT-1:0]              regionReadEnable,
    output logic [REGION_COUNT*DATA_WIDTH-1:0]   regionDataWrite,
    input  logic [REGION_COUNT*DATA_WIDTH-1:0]   regionDataRead,
    input  logic [REGION_COUNT-1:0]              regionBusy
);
    localparam int BW    = DATA_WIDTH / 8;
    localparam int SEL_W = (REGION_COUNT > 1) ? $clog2(REGION_COUNT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

    state_t                   state_q, state_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [ADDRESS_WIDTH-1:0] offset_q, offset_d;
    logic [BW-1:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     write_q, write_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     fault_q, fault_d;

    logic                     request;
    logic                     hit;
    logic [SEL_W-1:0]         hit_idx;
    logic [ADDRESS_WIDTH-1:0] hit_offset;
    logic                     complete;
    logic                     timeout;

    assign request  = coreReadEnable | coreWriteEnable;
    assign complete = ~regionBusy[sel_q];

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_offset = '0;
        for (int i = REGION_COUNT - 1; i >= 0; i--) begin
            if ((coreAddress & REGION_MASKS[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]) ==
                REGION_BASES[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]) begin
                hit        = 1'b1;
                hit_idx    = SEL_W'(i);
                hit_offset = coreAddress & ~REGION_MASKS[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end
        end
    end

`ifdef MEMORY_CONTROLLER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = (state_q == S_ACCESS) ? count_q + 1'b1 : '0;
        timeout = (state_q == S_ACCESS) && !complete && (count_d == CNT_W'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (request) state_d = hit ? S_ACCESS : S_RESPOND;
            S_ACCESS:  if (complete || timeout) state_d = S_RESPOND;
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        coreBusy          = 1'b0;
        regionAddress     = '0;
        regionByteSelect  = '0;
        regionWriteEnable = '0;
        regionReadEnable  = '0;
        regionDataWrite   = '0;
        if (rst) begin
            case (state_q)
                S_IDLE:   coreBusy = request;
                S_ACCESS: coreBusy = 1'b1;
                default:  coreBusy = 1'b0;
            endcase
        end
        for (int i = 0; i < REGION_COUNT; i++) begin
            if (state_q == S_ACCESS && sel_q == SEL_W'(i)) begin
                regionAddress[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] = offset_q;
                regionByteSelect[i*BW +: BW]                    = be_q;
                regionDataWrite[i*DATA_WIDTH +: DATA_WIDTH]     = wdata_q;
                regionWriteEnable[i]                            = write_q;
                regionReadEnable[i]                             = ~write_q;
            end
        end
    end

    always_comb begin
        sel_d    = sel_q;
        offset_d = offset_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        rdata_d  = rdata_q;
        fault_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (request && hit) begin
                    sel_d    = hit_idx;
                    offset_d = hit_offset;
                    be_d     = coreByteSelect;
                    wdata_d  = coreDataWrite;
                    write_d  = coreWriteEnable;
                end else if (request) begin
                    rdata_d = '1;
                    fault_d = 1'b1;
                end
            end
            S_ACCESS: begin
                if (complete) begin
                    rdata_d = regionDataRead[sel_q*DATA_WIDTH +: DATA_WIDTH];
                end else if (timeout) begin
                    rdata_d = '1;
                    fault_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_q    <= '0;
            offset_q <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            offset_q <= offset_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    assign coreDataRead = rdata_q;
    assign coreFault    = fault_q;

endmodule
